// File: rtl/fir_equalizer_param.sv
// Streaming signed FIR channel equaliser with double-buffered runtime coefficients,
// round-half-up, output saturation and a per-sample bypass path. Three-edge latency.
module fir_equalizer_param #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 31,
   parameter int FRAC   = 14
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic signed [DATA_W-1:0]  in_data,
   input  logic                      bypass,
   input  logic                      coef_we,
   input  logic [$clog2(TAPS)-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0]  coef_data,
   input  logic                      coef_commit,
   output logic                      out_valid,
   output logic signed [DATA_W-1:0]  out_data,
   output logic                      sat_flag
);

   localparam int AW    = $clog2(TAPS);
   localparam int PW    = DATA_W + COEF_W;
   localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
   localparam int RW    = ACC_W + 1;

   localparam logic signed [COEF_W-1:0] ONE   = COEF_W'(1) << FRAC;
   localparam logic signed [RW-1:0]     HALF  = RW'(1) << (FRAC - 1);
   localparam logic signed [RW-1:0]     MAX_V = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [RW-1:0]     MIN_V = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [COEF_W-1:0] shadow [TAPS];
   logic signed [COEF_W-1:0] active [TAPS];

   logic signed [DATA_W-1:0] dly [TAPS-1];
   logic signed [DATA_W-1:0] win [TAPS];

   logic signed [PW-1:0]     prod [TAPS];
   logic                     v1;
   logic                     b1;
   logic signed [DATA_W-1:0] s1;

   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  acc;
   logic                     v2;
   logic                     b2;
   logic signed [DATA_W-1:0] s2;

   logic signed [RW-1:0]     rnd;
   logic                     clip_hi;
   logic                     clip_lo;

   // A commit copies the pre-edge shadow, so a write on the same edge only reaches the shadow.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < TAPS; k++) begin
            shadow[k] <= (k == 0) ? ONE : '0;
            active[k] <= (k == 0) ? ONE : '0;
         end
      end else begin
         if (coef_commit) begin
            for (int k = 0; k < TAPS; k++) begin
               active[k] <= shadow[k];
            end
         end
         if (coef_we && (32'(coef_addr) < TAPS)) begin
            shadow[coef_addr] <= coef_data;
         end
      end
   end

   always_comb begin
      win[0] = in_data;
      for (int k = 1; k < TAPS; k++) begin
         win[k] = dly[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < TAPS - 1; k++) begin
            dly[k] <= '0;
         end
         for (int k = 0; k < TAPS; k++) begin
            prod[k] <= '0;
         end
         v1 <= 1'b0;
         b1 <= 1'b0;
         s1 <= '0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            for (int k = 0; k < TAPS - 1; k++) begin
               dly[k] <= win[k];
            end
            for (int k = 0; k < TAPS; k++) begin
               prod[k] <= PW'(win[k]) * PW'(active[k]);
            end
            b1 <= bypass;
            s1 <= in_data;
         end
      end
   end

   // The log2(TAPS) guard bits make this sum overflow-free.
   always_comb begin
      sum = '0;
      for (int k = 0; k < TAPS; k++) begin
         sum = sum + ACC_W'(prod[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc <= '0;
         v2  <= 1'b0;
         b2  <= 1'b0;
         s2  <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            acc <= sum;
            b2  <= b1;
            s2  <= s1;
         end
      end
   end

   always_comb begin
      rnd     = (RW'(acc) + HALF) >>> FRAC;
      clip_hi = (rnd > MAX_V);
      clip_lo = (rnd < MIN_V);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
      end else begin
         out_valid <= v2;
         if (v2) begin
            if (b2) begin
               out_data <= s2;
               sat_flag <= 1'b0;
            end else begin
               if (clip_hi) begin
                  out_data <= MAX_V[DATA_W-1:0];
               end else if (clip_lo) begin
                  out_data <= MIN_V[DATA_W-1:0];
               end else begin
                  out_data <= rnd[DATA_W-1:0];
               end
               sat_flag <= clip_hi | clip_lo;
            end
         end else begin
            sat_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_equalizer_param.sv
// Bench for fir_equalizer_param: directed scenarios plus a random segment, checked
// against an arithmetic model that stamps each accepted sample with its due cycle.
module tb_fir_equalizer_param;

   localparam int DW = 16;
   localparam int CW = 16;
   localparam int NT = 31;
   localparam int FR = 14;
   localparam int AW = $clog2(NT);

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          bypass;
   logic          coef_we;
   logic [AW-1:0] coef_addr;
   logic [CW-1:0] coef_data;
   logic          coef_commit;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          sat_flag;

   always #5 clk = ~clk;

   fir_equalizer_param #(
      .DATA_W(DW),
      .COEF_W(CW),
      .TAPS(NT),
      .FRAC(FR)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_data(in_data),
      .bypass(bypass),
      .coef_we(coef_we),
      .coef_addr(coef_addr),
      .coef_data(coef_data),
      .coef_commit(coef_commit),
      .out_valid(out_valid),
      .out_data(out_data),
      .sat_flag(sat_flag)
   );

   typedef struct {
      longint        due;
      logic [DW-1:0] d;
      logic          s;
   } tok_t;

   longint        hist [NT];
   longint        act  [NT];
   longint        shd  [NT];
   tok_t          pend [$];
   longint        cyc = 0;
   logic [DW-1:0] last_d = '0;
   int            total = 0;
   int            bad = 0;

   function automatic void model_reset();
      for (int k = 0; k < NT; k++) begin
         hist[k] = 0;
         act[k]  = (k == 0) ? (longint'(1) <<< FR) : 0;
         shd[k]  = act[k];
      end
      pend.delete();
      last_d = '0;
   endfunction

   function automatic void model_accept(input longint d, input logic b);
      longint acc;
      longint r;
      longint hi;
      longint lo;
      tok_t   t;
      for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
      acc = 0;
      for (int k = 0; k < NT; k++) acc += hist[k] * act[k];
      hi = (longint'(1) <<< (DW - 1)) - 1;
      lo = -(longint'(1) <<< (DW - 1));
      t.due = cyc + 2;
      if (b) begin
         t.d = DW'(d);
         t.s = 1'b0;
      end else begin
         r = (acc + (longint'(1) <<< (FR - 1))) >>> FR;
         t.s = (r > hi) || (r < lo);
         if (r > hi) r = hi;
         if (r < lo) r = lo;
         t.d = r[DW-1:0];
      end
      pend.push_back(t);
   endfunction

   task automatic check_output();
      logic ev;
      tok_t t;
      ev = (pend.size() > 0) && (pend[0].due == cyc);
      total++;
      assert (out_valid === ev) else begin
         bad++;
         $error("[TB] FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ev);
      end
      if (ev) begin
         t = pend.pop_front();
         total += 2;
         assert (out_data === t.d) else begin
            bad++;
            $error("[TB] FAIL out_data cyc=%0d got=%0d exp=%0d", cyc, $signed(out_data), $signed(t.d));
         end
         assert (sat_flag === t.s) else begin
            bad++;
            $error("[TB] FAIL sat_flag cyc=%0d got=%b exp=%b", cyc, sat_flag, t.s);
         end
         last_d = t.d;
      end else begin
         total += 2;
         assert (sat_flag === 1'b0) else begin
            bad++;
            $error("[TB] FAIL idle_sat cyc=%0d got=%b exp=0", cyc, sat_flag);
         end
         assert (out_data === last_d) else begin
            bad++;
            $error("[TB] FAIL hold_data cyc=%0d got=%0d exp=%0d", cyc, $signed(out_data), $signed(last_d));
         end
      end
   endtask

   // One clock of stimulus: drive on the falling edge, update the model at the rising edge.
   task automatic apply_stimulus(input logic rst_n, input logic v, input logic signed [DW-1:0] d,
                                 input logic b, input logic we, input int addr,
                                 input logic signed [CW-1:0] cd, input logic cm);
      @(negedge clk);
      reset       = rst_n;
      in_valid    = v;
      in_data     = d;
      bypass      = b;
      coef_we     = we;
      coef_addr   = AW'(addr);
      coef_data   = cd;
      coef_commit = cm;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         model_reset();
      end else begin
         if (v) model_accept(longint'(d), b);
         if (cm) for (int k = 0; k < NT; k++) act[k] = shd[k];
         if (we && (addr < NT)) shd[addr] = longint'(cd);
      end
      #1;
      check_output();
   endtask

   task automatic send(input logic signed [DW-1:0] d, input logic b);
      apply_stimulus(1'b1, 1'b1, d, b, 1'b0, 0, '0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 0, '0, 1'b0);
   endtask

   task automatic wr(input int addr, input logic signed [CW-1:0] cd);
      apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, addr, cd, 1'b0);
   endtask

   task automatic commit();
      apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 0, '0, 1'b1);
   endtask

   initial begin
      logic               rv;
      logic               rb;
      logic               rwe;
      logic               rcm;
      int                 raddr;
      logic signed [DW-1:0] rd;
      logic signed [CW-1:0] rc;

      apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 0, '0, 1'b0);
      apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 0, '0, 1'b0);

      $display("[TB] identity after reset");
      send(16'sd100, 1'b0);
      send(-16'sd200, 1'b0);
      send(16'sd32767, 1'b0);
      send(-16'sd32768, 1'b0);
      idle(3);

      $display("[TB] impulse response");
      for (int k = 0; k < NT; k++) wr(k, CW'(k + 1));
      commit();
      send(16'sd16384, 1'b0);
      for (int i = 0; i < 31; i++) send('0, 1'b0);
      idle(3);

      $display("[TB] rounding");
      wr(0, 16'sd8192);
      for (int k = 1; k < NT; k++) wr(k, '0);
      commit();
      send(16'sd3, 1'b0);
      send(-16'sd3, 1'b0);
      send(16'sd1, 1'b0);
      idle(3);

      $display("[TB] saturation");
      for (int k = 0; k < NT; k++) wr(k, 16'sd16384);
      commit();
      for (int i = 0; i < NT; i++) send(16'sd32767, 1'b0);
      idle(3);
      for (int i = 0; i < NT; i++) send(-16'sd32768, 1'b0);
      idle(3);

      $display("[TB] gaps and bypass");
      send(16'sd10, 1'b0);
      idle(2);
      send(16'sd20, 1'b0);
      send(16'sd30, 1'b0);
      send(16'sd500, 1'b1);
      idle(3);

      $display("[TB] commit and reset edges");
      wr(0, 16'sd8192);
      for (int k = 1; k < NT; k++) wr(k, '0);
      apply_stimulus(1'b1, 1'b1, 16'sd1000, 1'b0, 1'b0, 0, '0, 1'b1);
      send(16'sd1000, 1'b0);
      apply_stimulus(1'b1, 1'b1, 16'sd400, 1'b0, 1'b1, 0, 16'sd16384, 1'b1);
      send(16'sd400, 1'b0);
      wr(31, 16'sd4096);
      commit();
      send(16'sd400, 1'b0);
      send(16'sd7, 1'b0);
      send(16'sd8, 1'b0);
      apply_stimulus(1'b0, 1'b1, 16'sd9, 1'b0, 1'b0, 0, '0, 1'b0);
      idle(4);
      send(16'sd1234, 1'b0);
      idle(3);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         rv    = ($urandom_range(0, 9) < 7);
         rb    = ($urandom_range(0, 9) == 0);
         rwe   = ($urandom_range(0, 2) == 0);
         rcm   = ($urandom_range(0, 29) == 0);
         raddr = int'($urandom_range(0, NT));
         rc    = CW'(int'($urandom_range(0, 16383)) - 8192);
         rd    = DW'($urandom);
         apply_stimulus(1'b1, rv, rd, rb, rwe, raddr, rc, rcm);
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
